bus_ram: RTL and testbench

Parametrised single-port synchronous RAM with a valid/ready request and response interface, per-byte write enables and a hardware clear engine. It replaces the fixed 256x8 RAM on the CPU bus. Memory is cleared by a sequential sweep, not a single-cycle array reset, so it maps to block RAM. Reads return through a one-entry response register with back-pressure, so the bus master can stall.

---
 rtl/bus_ram_if.sv | 32 +++
 rtl/bus_ram.sv | 97 +++++++++
 tb/tb_bus_ram.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_ram_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_ram_if : request/response bus and clear control for bus_ram            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface bus_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  clr_start;
    logic                  busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, clr_start,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, clr_start,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/bus_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_ram : single-port RAM, valid/ready bus, byte enables, clear sweep    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bus_ram #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    bus_ram_if.slave   bus
);
    localparam int c_depth  = 2 ** ADDR_W;
    localparam int c_nbytes = DATA_W / 8;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t c_rst_state = state_t'(INIT_CLEAR);

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("bus_ram: DATA_W must be a multiple of 8");
    end

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_ptr_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [DATA_W-1:0]   mem_q [c_depth];

    logic w_run;
    logic w_slot_free;
    logic w_accept;
    logic w_wr;
    logic w_rd;

    assign w_run       = (state_q == ST_RUN);
    assign w_slot_free = !rsp_valid_q || bus.rsp_ready;
    assign w_accept    = bus.req_valid && w_run && w_slot_free;
    assign w_wr        = w_accept && bus.req_we;
    assign w_rd        = w_accept && !bus.req_we;

    // rst only gates the visible ready; the flops are already held by reset
    assign bus.req_ready = !rst && w_run && w_slot_free;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = (state_q == ST_CLEAR);

    // Array kept out of the reset domain so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < c_nbytes; i++) begin
                if (bus.req_be[i]) begin
                    mem_q[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_rst_state;
            clr_ptr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (w_rd) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= mem_q[bus.req_addr];
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end

            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
                    if (clr_ptr_q == {ADDR_W{1'b1}}) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    // A request accepted on this edge still completes above
                    if (bus.clr_start && !rsp_valid_q) begin
                        state_q <= ST_CLEAR;
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bus_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bus_ram : vector table plus scoreboarded corner sequences for bus_ram |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bus_ram;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bus_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();

    bus_ram #(.DATA_W(DW), .ADDR_W(AW), .INIT_CLEAR(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [$];
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every response handshake pops one expected word
    always @(negedge clk) begin
        if (!rst && bif.rsp_valid && bif.rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got 0x%08h expected no response", bif.rsp_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp_rdata", bif.rsp_rdata, mon_exp);
            end
        end
    end

    task automatic req(input logic we, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] exp, input bit push);
        int n;
        bif.req_valid = 1'b1;
        bif.req_we    = we;
        bif.req_addr  = a;
        bif.req_wdata = d;
        bif.req_be    = be;
        if (!we && push) exp_q.push_back(exp);
        n = 0;
        forever begin
            @(negedge clk);
            if (bif.req_ready) break;
            n++;
            if (n > 200) begin
                check("req_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bif.req_valid = 1'b0;
        bif.req_we    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (bif.rsp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bif.rsp_valid) check("drain_timeout", 32'd1, 32'd0);
    endtask

    // Counts edges until busy falls; req_ready must stay low throughout
    task automatic sweep_check(input string name);
        int cnt;
        logic bad;
        cnt = 0;
        bad = 1'b0;
        while (bif.busy && cnt < 100) begin
            if (bif.req_ready) bad = 1'b1;
            @(posedge clk);
            #1;
            cnt++;
        end
        check({name, "_cycles"}, 32'(cnt), 32'(DEPTH));
        check({name, "_ready_low"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.req_valid = 1'b0;
        bif.req_we    = 1'b0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.req_be    = '0;
        bif.rsp_ready = 1'b0;
        bif.clr_start = 1'b0;

        // Reset and initial sweep
        #2 rst = 1'b1;
        #1;
        check("rst_busy",      32'(bif.busy),      32'd1);
        check("rst_req_ready", 32'(bif.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bif.rsp_rdata,      32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sweep_check("init_sweep");
        bif.rsp_ready = 1'b1;
        check("init_ready_up", 32'(bif.req_ready), 32'd1);

        // Vector table: back-to-back requests with rsp_ready held high
        for (int i = 0; i < DEPTH; i++)
            tbl.push_back(vec_t'{1'b0, 4'(i), 32'h0, 4'h0, 32'h0});
        tbl.push_back(vec_t'{1'b1, 4'd3,  32'hAABBCCDD, 4'hF,    32'h0});
        tbl.push_back(vec_t'{1'b1, 4'd3,  32'h11223344, 4'b0101, 32'h0});
        tbl.push_back(vec_t'{1'b0, 4'd3,  32'h0,        4'h0,    32'hAA22CC44});
        tbl.push_back(vec_t'{1'b1, 4'd5,  32'h12345678, 4'hF,    32'h0});
        tbl.push_back(vec_t'{1'b1, 4'd5,  32'hFFFFFFFF, 4'h0,    32'h0});
        tbl.push_back(vec_t'{1'b0, 4'd5,  32'h0,        4'h0,    32'h12345678});
        tbl.push_back(vec_t'{1'b1, 4'd15, 32'hDEADBEEF, 4'b1000, 32'h0});
        tbl.push_back(vec_t'{1'b0, 4'd15, 32'h0,        4'h0,    32'hDE000000});
        tbl.push_back(vec_t'{1'b1, 4'd1,  32'h01010101, 4'hF,    32'h0});
        tbl.push_back(vec_t'{1'b1, 4'd2,  32'h02020202, 4'hF,    32'h0});
        tbl.push_back(vec_t'{1'b0, 4'd1,  32'h0,        4'h0,    32'h01010101});
        tbl.push_back(vec_t'{1'b0, 4'd2,  32'h0,        4'h0,    32'h02020202});
        foreach (tbl[k])
            req(tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].be, tbl[k].exp, 1'b1);
        drain();

        // Back-to-back reads, stall on the second response
        bif.req_valid = 1'b1;
        bif.req_we    = 1'b0;
        bif.req_addr  = 4'd1;
        exp_q.push_back(32'h01010101);
        @(posedge clk);
        #1;
        bif.req_addr = 4'd2;
        exp_q.push_back(32'h02020202);
        @(posedge clk);
        #1;
        bif.rsp_ready = 1'b0;
        bif.req_addr  = 4'd3;
        exp_q.push_back(32'hAA22CC44);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_req_ready", 32'(bif.req_ready), 32'd0);
            check("stall_rsp_rdata", bif.rsp_rdata, 32'h02020202);
        end
        @(posedge clk);
        #1 bif.rsp_ready = 1'b1;
        @(negedge clk);
        check("unstall_req_ready", 32'(bif.req_ready), 32'd1);
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
        @(posedge clk);
        #1;
        drain();

        // Runtime clear
        req(1'b1, 4'd7, 32'h0000005A, 4'b0001, 32'h0, 1'b0);
        drain();
        bif.clr_start = 1'b1;
        @(posedge clk);
        #1 bif.clr_start = 1'b0;
        check("rtclr_busy", 32'(bif.busy), 32'd1);
        sweep_check("rtclr_sweep");
        req(1'b0, 4'd7, 32'h0, 4'h0, 32'h0, 1'b1);
        drain();

        // Clear start coinciding with an accepted write
        bif.clr_start = 1'b1;
        req(1'b1, 4'd0, 32'h00000033, 4'b0001, 32'h0, 1'b0);
        bif.clr_start = 1'b0;
        check("clrwr_busy", 32'(bif.busy), 32'd1);
        sweep_check("clrwr_sweep");
        req(1'b0, 4'd0, 32'h0, 4'h0, 32'h0, 1'b1);
        req(1'b0, 4'd1, 32'h0, 4'h0, 32'h0, 1'b1);
        drain();

        // Clear start ignored while a response is pending
        req(1'b1, 4'd4, 32'h00000077, 4'b0001, 32'h0, 1'b0);
        bif.rsp_ready = 1'b0;
        req(1'b0, 4'd4, 32'h0, 4'h0, 32'h00000077, 1'b1);
        bif.clr_start = 1'b1;
        @(posedge clk);
        #1 bif.clr_start = 1'b0;
        check("pend_clr_busy", 32'(bif.busy), 32'd0);
        check("pend_clr_ready", 32'(bif.req_ready), 32'd0);
        bif.rsp_ready = 1'b1;
        drain();
        req(1'b0, 4'd4, 32'h0, 4'h0, 32'h00000077, 1'b1);
        drain();

        // Reset five cycles into a sweep
        bif.clr_start = 1'b1;
        @(posedge clk);
        #1 bif.clr_start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midsweep_rst_busy",  32'(bif.busy),      32'd1);
        check("midsweep_rst_ready", 32'(bif.req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sweep_check("midsweep_resweep");

        // Reset with a response pending
        req(1'b1, 4'd6, 32'h00000099, 4'b0001, 32'h0, 1'b0);
        bif.rsp_ready = 1'b0;
        req(1'b0, 4'd6, 32'h0, 4'h0, 32'h0, 1'b0);
        check("pend_rsp_valid", 32'(bif.rsp_valid), 32'd1);
        check("pend_rsp_rdata", bif.rsp_rdata, 32'h00000099);
        #2 rst = 1'b1;
        #1;
        check("rsprst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        check("rsprst_rsp_rdata", bif.rsp_rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        bif.rsp_ready = 1'b1;
        sweep_check("rsprst_resweep");
        req(1'b0, 4'd6, 32'h0, 4'h0, 32'h0, 1'b1);
        drain();
        repeat (2) @(posedge clk);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
